// File: rtl/p2s_frame_tx.sv
// Parallel-to-serial async frame transmitter: start bit, DATA_W data bits, optional parity, 1-2 stop bits.
// One-word holding register behind a valid/ready handshake keeps back-to-back frames gap-free.
module p2s_frame_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned MSB_FIRST    = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [DATA_W-1:0] P_data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              abort,
    output logic              S_data_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic               par_q, par_d;
    logic               line_q, line_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept_c;
    logic               baud_end_c;
    logic               load_c;
    logic [DATA_W-1:0]  load_word_c;

    assign data_ready = ready_q;
    assign S_data_out = line_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            line_q      <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            line_q      <= line_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        accept_c    = data_valid & ready_q & ~abort;
        baud_end_c  = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
        state_d     = state_q;
        baud_d      = baud_end_c ? '0 : baud_q + CNT_W'(1);
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        hold_d      = accept_c ? P_data_in : hold_q;
        hold_full_d = hold_full_q | accept_c;
        load_c      = 1'b0;
        load_word_c = hold_q;

        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (hold_full_q) begin
                    load_c = 1'b1;
                end
            end
            ST_START: begin
                if (baud_end_c) begin
                    state_d  = ST_DATA;
                    bitcnt_d = '0;
                end
            end
            ST_DATA: begin
                if (baud_end_c) begin
                    shift_d = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], 1'b0}
                                               : {1'b0, shift_q[DATA_W-1:1]};
                    if (bitcnt_q == BIT_W'(DATA_W - 1)) begin
                        state_d  = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_end_c) begin
                    state_d  = ST_STOP;
                    bitcnt_d = '0;
                end
            end
            ST_STOP: begin
                if (baud_end_c) begin
                    if (bitcnt_q == BIT_W'(STOP_BITS - 1)) begin
                        // A word handed over during the last stop cycle bypasses the holding register
                        if (hold_full_q) begin
                            load_c = 1'b1;
                        end else if (accept_c) begin
                            load_c      = 1'b1;
                            load_word_c = P_data_in;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_c) begin
            state_d     = ST_START;
            baud_d      = '0;
            bitcnt_d    = '0;
            shift_d     = load_word_c;
            par_d       = (^load_word_c) ^ 1'(PARITY_ODD);
            hold_full_d = 1'b0;
        end

        if (abort) begin
            state_d     = ST_IDLE;
            baud_d      = '0;
            bitcnt_d    = '0;
            hold_full_d = 1'b0;
        end

        unique case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = (MSB_FIRST != 0) ? shift_d[DATA_W-1] : shift_d[0];
            ST_PARITY: line_d = par_d;
            default:   line_d = 1'b1;
        endcase

        ready_d = ~hold_full_d & ~abort;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_STOP) &&
                  (baud_d == CNT_W'(CLKS_PER_BIT - 1)) &&
                  (bitcnt_d == BIT_W'(STOP_BITS - 1));
    end

endmodule

// File: tb/tb_p2s_frame_tx.sv
// Directed bench for p2s_frame_tx: two configurations, per-cycle line checks against hand-built frame patterns.
module tb_p2s_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] p_a = 8'h00, p_b = 8'h00;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       abort_a = 1'b0, abort_b = 1'b0;
    logic       ready_a, ready_b, line_a, line_b, busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    p2s_frame_tx #(
        .DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0),
        .STOP_BITS(1), .MSB_FIRST(1)
    ) dut_a (
        .CLOCK_50(clk), .reset(rst_n), .P_data_in(p_a), .data_valid(valid_a),
        .data_ready(ready_a), .abort(abort_a), .S_data_out(line_a),
        .busy(busy_a), .frame_done(done_a)
    );

    p2s_frame_tx #(
        .DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0),
        .STOP_BITS(2), .MSB_FIRST(0)
    ) dut_b (
        .CLOCK_50(clk), .reset(rst_n), .P_data_in(p_b), .data_valid(valid_b),
        .data_ready(ready_b), .abort(abort_b), .S_data_out(line_b),
        .busy(busy_b), .frame_done(done_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input logic [7:0] d);
        if (which == 0) begin valid_a = v; p_a = d; end
        else            begin valid_b = v; p_b = d; end
    endtask

    // Handshake a word from idle; returns at the first cycle of its start bit
    task automatic kick(input int which, input logic [7:0] w, input string tag);
        drive(which, 1'b1, w);
        @(negedge clk);
        chk({tag, "_acc_rdy"},  which == 0 ? ready_a : ready_b, 1'b0);
        chk({tag, "_acc_line"}, which == 0 ? line_a  : line_b,  1'b1);
        chk({tag, "_acc_busy"}, which == 0 ? busy_a  : busy_b,  1'b0);
        drive(which, 1'b0, w);
        @(negedge clk);
    endtask

    // Checks one frame cycle by cycle (4 clocks per bit); optionally offers set_d at cycle set_c,
    // then offers junk while the holding register is full and finally withdraws valid.
    task automatic check_frame(input int which, input logic [15:0] pat, input int nbits,
                               input int set_c, input logic [7:0] set_d, input string tag);
        logic exp_line;
        logic exp_rdy;
        for (int c = 0; c < nbits * 4; c++) begin
            exp_line = pat[4'(nbits - 1 - c / 4)];
            exp_rdy  = (set_c < 0 || c <= set_c) ? 1'b1 : 1'b0;
            chk($sformatf("%s_line_c%0d", tag, c), which == 0 ? line_a : line_b, exp_line);
            chk($sformatf("%s_busy_c%0d", tag, c), which == 0 ? busy_a : busy_b, 1'b1);
            chk($sformatf("%s_done_c%0d", tag, c), which == 0 ? done_a : done_b,
                (c == nbits * 4 - 1) ? 1'b1 : 1'b0);
            chk($sformatf("%s_rdy_c%0d", tag, c), which == 0 ? ready_a : ready_b, exp_rdy);
            if (set_c >= 0 && c == set_c)     drive(which, 1'b1, set_d);
            if (set_c >= 0 && c == set_c + 1) drive(which, 1'b1, 8'h99);
            if (set_c >= 0 && c == set_c + 4) drive(which, 1'b0, 8'h99);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input int which, input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            chk($sformatf("%s_line_c%0d", tag, c), which == 0 ? line_a : line_b, 1'b1);
            chk($sformatf("%s_busy_c%0d", tag, c), which == 0 ? busy_a : busy_b, 1'b0);
            chk($sformatf("%s_done_c%0d", tag, c), which == 0 ? done_a : done_b, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset values on both configurations
        repeat (2) @(negedge clk);
        chk("rst_line_a", line_a, 1'b1);
        chk("rst_rdy_a",  ready_a, 1'b1);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_done_a", done_a, 1'b0);
        chk("rst_line_b", line_b, 1'b1);
        chk("rst_rdy_b",  ready_b, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(0, 3, "idle0");

        // 8'hA5 MSB first, no parity, 1 stop: 0 10100101 1
        kick(0, 8'hA5, "a5");
        check_frame(0, 16'b0101001011, 10, -1, 8'h00, "a5");
        check_idle(0, 3, "a5_after");

        // 8'h07 LSB first, even parity, 2 stops: 0 11100000 1 11
        kick(1, 8'h07, "p07");
        check_frame(1, 16'b011100000111, 12, -1, 8'h00, "p07");
        check_idle(1, 3, "p07_after");

        // Back-to-back 8'h55 then 8'hFF queued mid-DATA; junk 8'h99 offered while full is ignored
        kick(0, 8'h55, "b2b");
        check_frame(0, 16'b0010101011, 10, 10, 8'hFF, "b2b1");
        check_frame(0, 16'b0111111111, 10, -1, 8'h00, "b2b2");
        check_idle(0, 12, "b2b_after");

        // Handshake during the frame_done cycle with empty holding starts with no gap
        kick(0, 8'h0F, "byp");
        check_frame(0, 16'b0000011111, 10, 39, 8'hC3, "byp1");
        drive(0, 1'b0, 8'h00);
        check_frame(0, 16'b0110000111, 10, -1, 8'h00, "byp2");
        check_idle(0, 3, "byp_after");

        // Abort mid-DATA of 8'h3C with 8'h81 queued
        drive(0, 1'b1, 8'h3C);
        @(negedge clk);
        chk("abt_acc_rdy", ready_a, 1'b0);
        drive(0, 1'b1, 8'h81);
        @(negedge clk);
        chk("abt_c1_line", line_a, 1'b0);
        chk("abt_c1_rdy",  ready_a, 1'b1);
        @(negedge clk);
        chk("abt_q_rdy", ready_a, 1'b0);
        drive(0, 1'b0, 8'h00);
        repeat (8) @(negedge clk);
        chk("abt_mid_line", line_a, 1'b0);
        chk("abt_mid_busy", busy_a, 1'b1);
        abort_a = 1'b1;
        @(negedge clk);
        chk("abt_line", line_a, 1'b1);
        chk("abt_busy", busy_a, 1'b0);
        chk("abt_done", done_a, 1'b0);
        chk("abt_rdy",  ready_a, 1'b0);
        @(negedge clk);
        chk("abt_hold_rdy",  ready_a, 1'b0);
        chk("abt_hold_line", line_a, 1'b1);
        abort_a = 1'b0;
        @(negedge clk);
        chk("abt_rel_rdy", ready_a, 1'b1);
        check_idle(0, 50, "abt_after");

        // Reset mid-STOP with holding full
        drive(0, 1'b1, 8'h12);
        @(negedge clk);
        drive(0, 1'b1, 8'h34);
        @(negedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        chk("rs_q_rdy", ready_a, 1'b0);
        repeat (36) @(negedge clk);
        chk("rs_stop_line", line_a, 1'b1);
        chk("rs_stop_busy", busy_a, 1'b1);
        chk("rs_stop_rdy",  ready_a, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rs_line", line_a, 1'b1);
        chk("rs_rdy",  ready_a, 1'b1);
        chk("rs_busy", busy_a, 1'b0);
        chk("rs_done", done_a, 1'b0);
        rst_n = 1'b1;
        check_idle(0, 60, "rs_after");
        chk("rs_after_rdy", ready_a, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
